// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch queue entries, fetch FSM states and PC helpers.
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    fetch_state_t state;
    logic [7:0]   q_count;
  } fetch_dbg_t;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous first-word-fall-through FIFO of fetch entries with flush.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push;
  logic           do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  // Head reads as zero when empty so downstream never sees stale data.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational instruction memory and
// buffers {pc, instr} in a prefetch queue that feeds decode.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            fetch_halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] instr_count,
  output fetch_dbg_t      dbg
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_count_q, instr_count_d;
  logic            deq;
  logic            enq;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;

  // Decode handshake: a transfer happens on any cycle where if_valid && if_ready;
  // if_valid/if_instr/if_pc hold steady until that transfer, and if_ready may
  // be high while if_valid is low without effect.
  assign if_valid    = !q_empty;
  assign if_instr    = head.instr;
  assign if_pc       = head.pc;
  assign if_pc_plus4 = q_empty ? '0 : pc_inc(head.pc);
  assign imem_addr   = pc_q;
  assign instr_count = instr_count_q;
  assign dbg.state   = state_q;
  assign dbg.q_count = 8'(q_count);

  always_comb begin
    deq              = if_valid && if_ready;
    enq              = (state_q == FS_RUN) && !fetch_halt && !redirect_valid
                       && (!q_full || deq);
    push_entry.pc    = pc_q;
    push_entry.instr = imem_instr;
    instr_count_d    = instr_count_q + XLEN'(deq);
    pc_d             = pc_q;
    if (redirect_valid) begin
      pc_d = pc_align(redirect_pc);
    end else if (enq) begin
      pc_d = pc_inc(pc_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_RUN:  if (fetch_halt && !redirect_valid) state_d = FS_HALT;
      FS_HALT: if (!fetch_halt || redirect_valid) state_d = FS_RUN;
      default: state_d = FS_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FS_RUN;
      pc_q          <= RESET_PC;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_count_q <= instr_count_d;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (enq),
    .push_entry (push_entry),
    .pop        (deq),
    .flush      (redirect_valid),
    .head       (head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 256-word combinational imem model.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [256];

  logic        rst, fetch_halt, redirect_valid, if_ready, if_valid;
  logic [31:0] imem_addr, imem_instr, redirect_pc, if_instr, if_pc, if_pc_plus4, instr_count;
  fetch_dbg_t  dbg;

  logic        rst_w, fetch_halt_w, redirect_valid_w, if_ready_w, if_valid_w;
  logic [31:0] imem_addr_w, imem_instr_w, redirect_pc_w, if_instr_w, if_pc_w, if_pc_plus4_w, instr_count_w;
  fetch_dbg_t  dbg_w;

  int errors = 0;
  int checks = 0;

  assign imem_instr   = imem[imem_addr[9:2]];
  assign imem_instr_w = imem[imem_addr_w[9:2]];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .fetch_halt(fetch_halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .instr_count(instr_count), .dbg(dbg)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) u_dut_wrap (
    .clk(clk), .rst(rst_w), .imem_addr(imem_addr_w), .imem_instr(imem_instr_w),
    .fetch_halt(fetch_halt_w), .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .if_valid(if_valid_w), .if_ready(if_ready_w), .if_instr(if_instr_w), .if_pc(if_pc_w),
    .if_pc_plus4(if_pc_plus4_w), .instr_count(instr_count_w), .dbg(dbg_w)
  );

  task automatic do_reset();
    rst = 1'b1; fetch_halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", if_valid); end
    checks++; if (instr_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0h expected 0", instr_count); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL reset_head: got pc=%h instr=%h pc4=%h expected all 0", if_pc, if_instr, if_pc_plus4); end
    checks++; if (dbg.state !== FS_RUN) begin errors++; $display("FAIL reset_state: got %0d expected RUN", dbg.state); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_instr [4];
    exp_instr[0] = 32'h2008_0005; exp_instr[1] = 32'h2009_000A;
    exp_instr[2] = 32'h0109_5020; exp_instr[3] = 32'hAC0A_0000;
    do_reset();
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== exp_instr[i]) begin
        errors++; $display("FAIL stream_%0d: got v=%0h pc=%h instr=%h expected v=1 pc=%h instr=%h",
                           i, if_valid, if_pc, if_instr, 32'(4 * i), exp_instr[i]); end
      checks++; if (instr_count !== 32'(i) || if_pc_plus4 !== 32'(4 * i + 4)) begin
        errors++; $display("FAIL stream_cnt_%0d: got cnt=%0d pc4=%h expected cnt=%0d pc4=%h",
                           i, instr_count, if_pc_plus4, i, 32'(4 * i + 4)); end
    end
    if_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    if_ready = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (imem_addr !== 32'h8 || dbg.q_count !== 8'd2) begin
      errors++; $display("FAIL stall_full: got addr=%h qcount=%0d expected addr=00000008 qcount=2", imem_addr, dbg.q_count); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || instr_count !== 32'h0) begin
      errors++; $display("FAIL stall_head: got v=%0h pc=%h cnt=%0d expected v=1 pc=0 cnt=0", if_valid, if_pc, instr_count); end
    if_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin
        errors++; $display("FAIL stall_release_%0d: got v=%0h pc=%h expected v=1 pc=%h", i, if_valid, if_pc, 32'(4 * i)); end
    end
    checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL stall_count: got %0d expected 3", instr_count); end
    if_ready = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    if_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL redir_pre: got pc=%h expected 00000004", if_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h13;
    @(negedge clk);
    redirect_valid = 1'b0; redirect_pc = '0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h10 || instr_count !== 32'd2) begin
      errors++; $display("FAIL redir_flush: got v=%0h addr=%h cnt=%0d expected v=0 addr=00000010 cnt=2",
                         if_valid, imem_addr, instr_count); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_pc_plus4 !== 32'h14 || if_instr !== 32'h1000_0004) begin
      errors++; $display("FAIL redir_target: got v=%0h pc=%h pc4=%h instr=%h expected v=1 pc=10 pc4=14 instr=10000004",
                         if_valid, if_pc, if_pc_plus4, if_instr); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h14) begin errors++; $display("FAIL redir_next: got pc=%h expected 00000014", if_pc); end
    if_ready = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    if_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dbg.q_count !== 8'd2) begin errors++; $display("FAIL halt_fill: got qcount=%0d expected 2", dbg.q_count); end
    fetch_halt = 1'b1; if_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || dbg.state !== FS_HALT || imem_addr !== 32'h8) begin
      errors++; $display("FAIL halt_drain: got v=%0h pc=%h st=%0d addr=%h expected v=1 pc=4 st=1 addr=8",
                         if_valid, if_pc, dbg.state, imem_addr); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL halt_empty: got v=%0h addr=%h expected v=0 addr=8", if_valid, imem_addr); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h8 || instr_count !== 32'd2) begin
      errors++; $display("FAIL halt_hold: got v=%0h addr=%h cnt=%0d expected v=0 addr=8 cnt=2", if_valid, imem_addr, instr_count); end
    fetch_halt = 1'b0;
    @(negedge clk);
    checks++; if (dbg.state !== FS_RUN || if_valid !== 1'b0) begin
      errors++; $display("FAIL halt_exit: got st=%0d v=%0h expected st=0 v=0", dbg.state, if_valid); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h0109_5020) begin
      errors++; $display("FAIL halt_resume: got v=%0h pc=%h instr=%h expected v=1 pc=8 instr=01095020", if_valid, if_pc, if_instr); end
    if_ready = 1'b0;
  endtask

  task automatic test_pc_wrap();
    rst_w = 1'b1; if_ready_w = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (imem_addr_w !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_reset_addr: got %h expected FFFFFFF8", imem_addr_w); end
    rst_w = 1'b0;
    @(negedge clk);
    checks++; if (if_pc_w !== 32'hFFFF_FFF8 || if_pc_plus4_w !== 32'hFFFF_FFFC || if_instr_w !== 32'h1000_00FE) begin
      errors++; $display("FAIL wrap_0: got pc=%h pc4=%h instr=%h expected FFFFFFF8 FFFFFFFC 100000FE", if_pc_w, if_pc_plus4_w, if_instr_w); end
    @(negedge clk);
    checks++; if (if_pc_w !== 32'hFFFF_FFFC || if_pc_plus4_w !== 32'h0 || if_instr_w !== 32'h1000_00FF) begin
      errors++; $display("FAIL wrap_1: got pc=%h pc4=%h instr=%h expected FFFFFFFC 00000000 100000FF", if_pc_w, if_pc_plus4_w, if_instr_w); end
    @(negedge clk);
    checks++; if (if_pc_w !== 32'h0 || if_pc_plus4_w !== 32'h4 || if_instr_w !== 32'h2008_0005) begin
      errors++; $display("FAIL wrap_2: got pc=%h pc4=%h instr=%h expected 00000000 00000004 20080005", if_pc_w, if_pc_plus4_w, if_instr_w); end
    if_ready_w = 1'b0; rst_w = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (instr_count !== 32'd7) begin errors++; $display("FAIL mid_count: got %0d expected 7", instr_count); end
    if_ready = 1'b0;
    @(negedge clk);
    checks++; if (dbg.q_count !== 8'd2 || instr_count !== 32'd7) begin
      errors++; $display("FAIL mid_full: got qcount=%0d cnt=%0d expected qcount=2 cnt=7", dbg.q_count, instr_count); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || instr_count !== 32'h0 || imem_addr !== 32'h0 || dbg.q_count !== 8'd0) begin
      errors++; $display("FAIL mid_reset: got v=%0h cnt=%0d addr=%h qcount=%0d expected v=0 cnt=0 addr=0 qcount=0",
                         if_valid, instr_count, imem_addr, dbg.q_count); end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h1000_0000 | 32'(i);
    imem[0] = 32'h2008_0005; imem[1] = 32'h2009_000A;
    imem[2] = 32'h0109_5020; imem[3] = 32'hAC0A_0000;
    rst_w = 1'b1; fetch_halt_w = 1'b0; redirect_valid_w = 1'b0; redirect_pc_w = '0; if_ready_w = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_pc_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
